// File: rtl/rat_uart_io_if.sv
// RAT MCU I/O bus bundle between the CPU core and a port-mapped peripheral.
//   IO_STRB  : one-cycle write strobe from the core's OUT instruction
//   PORT_ID  : port address, valid for both reads and writes
//   OUT_PORT : write data from the core
//   IN_PORT  : read data back to the core (combinational on PORT_ID)
//   INTR     : level interrupt request to the core
// master = core side, slave = peripheral side.
interface rat_uart_io_if;
  logic       IO_STRB;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic [7:0] IN_PORT;
  logic       INTR;

  modport master (
    output IO_STRB, PORT_ID, OUT_PORT,
    input  IN_PORT, INTR
  );

  modport slave (
    input  IO_STRB, PORT_ID, OUT_PORT,
    output IN_PORT, INTR
  );
endinterface

// File: rtl/rat_uart_io.sv
// UART peripheral on the RAT MCU I/O bus.
// TX_DEPTH-entry TX FIFO feeding an 8N1 serializer, 8N1 receiver with a
// one-byte holding register, two decoded ports and a level interrupt.
// Ports:
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : core I/O bus (slave side): IO_STRB, PORT_ID, OUT_PORT in;
//           IN_PORT, INTR out
//   RXD   : serial input, asynchronous to CLK
//   TXD   : serial output, idle high
// Register map: BASE_ID = data (write pushes TX FIFO, read returns RX byte),
// BASE_ID+1 = control (write) / status (read).
module rat_uart_io #(
  parameter logic [7:0] BASE_ID      = 8'h40,
  parameter int         CLKS_PER_BIT = 868,
  parameter int         TX_DEPTH     = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  rat_uart_io_if.slave bus,
  input  logic         RXD,
  output logic         TXD
);

  localparam int         AW        = $clog2(TX_DEPTH);
  localparam logic [7:0] CTRL_ID   = 8'(BASE_ID + 8'd1);
  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus decode ----------------
  logic data_sel, ctrl_sel, wr_data, ack, push, push_drop, pop;
  assign data_sel  = (bus.PORT_ID == BASE_ID);
  assign ctrl_sel  = (bus.PORT_ID == CTRL_ID);
  assign wr_data   = bus.IO_STRB & data_sel;
  assign ack       = bus.IO_STRB & ctrl_sel & bus.OUT_PORT[0];

  // ---------------- TX FIFO ----------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        tx_empty, tx_full;

  assign tx_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign tx_full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push      = wr_data & ~tx_full;
  assign push_drop = wr_data & tx_full;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.OUT_PORT;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // ---------------- TX serializer ----------------
  tx_state_t   tx_state_reg;
  logic [11:0] tx_cnt_reg;
  logic [2:0]  tx_bit_reg;
  logic [7:0]  tx_shift_reg;
  logic        txd_reg;
  logic        tx_busy, tx_bit_end;

  assign tx_busy    = (tx_state_reg != TX_IDLE);
  assign tx_bit_end = (tx_cnt_reg == BIT_LAST);
  // Head is consumed when leaving IDLE or at the end of a stop bit.
  assign pop = ~tx_empty & ((tx_state_reg == TX_IDLE) ||
                            (tx_state_reg == TX_STOP && tx_bit_end));
  assign TXD = txd_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      tx_cnt_reg <= tx_bit_end ? 12'd0 : tx_cnt_reg + 12'd1;
      case (tx_state_reg)
        TX_IDLE: begin
          tx_cnt_reg <= '0;
          if (!tx_empty) begin
            tx_state_reg <= TX_START;
            tx_shift_reg <= fifo_mem[rd_ptr_reg[AW-1:0]];
            txd_reg      <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state_reg <= TX_DATA;
            tx_bit_reg   <= '0;
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_reg == 3'd7) begin
              tx_state_reg <= TX_STOP;
              txd_reg      <= 1'b1;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              txd_reg      <= tx_shift_reg[0];
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            end
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            if (!tx_empty) begin
              // back-to-back frame, no idle gap
              tx_state_reg <= TX_START;
              tx_shift_reg <= fifo_mem[rd_ptr_reg[AW-1:0]];
              txd_reg      <= 1'b0;
            end else begin
              tx_state_reg <= TX_IDLE;
            end
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX deserializer ----------------
  rx_state_t   rx_state_reg;
  logic [11:0] rx_cnt_reg;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg;
  logic        rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;
  logic        rx_load, rx_bad, rx_stop_sample;

  assign rx_stop_sample = (rx_state_reg == RX_STOP) && (rx_cnt_reg == BIT_LAST);
  assign rx_load        = rx_stop_sample &  rxd_sync_reg;
  assign rx_bad         = rx_stop_sample & ~rxd_sync_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_prev_reg <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rxd_meta_reg <= RXD;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_prev_reg <= rxd_sync_reg;
      rx_cnt_reg   <= rx_cnt_reg + 12'd1;
      case (rx_state_reg)
        RX_IDLE: begin
          rx_cnt_reg <= '0;
          if (rxd_prev_reg && !rxd_sync_reg) rx_state_reg <= RX_START;
        end
        RX_START: begin
          // First sample lands half a bit after the falling edge; every later
          // sample is one full bit further, i.e. mid-bit.
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rxd_sync_reg ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rxd_sync_reg, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
            else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
          end
        end
        RX_STOP: begin
          // Leave half a bit early so a back-to-back start edge is seen.
          if (rx_stop_sample) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------- status, control, interrupt ----------------
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg, rx_ovf_reg, ferr_reg, tx_ovf_reg;
  logic       tx_ie_reg, rx_ie_reg, intr_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_ovf_reg   <= 1'b0;
      ferr_reg     <= 1'b0;
      tx_ovf_reg   <= 1'b0;
      tx_ie_reg    <= 1'b0;
      rx_ie_reg    <= 1'b0;
      intr_reg     <= 1'b0;
    end else begin
      if (rx_load) rx_data_reg <= rx_shift_reg;
      // A completing byte beats a simultaneous acknowledge for RX_VALID,
      // but the acknowledge still clears the overrun.
      rx_valid_reg <= rx_load | (rx_valid_reg & ~ack);
      rx_ovf_reg   <= ~ack & (rx_ovf_reg | (rx_load & rx_valid_reg));
      ferr_reg     <= rx_bad | (ferr_reg & ~ack);
      tx_ovf_reg   <= push_drop | (tx_ovf_reg & ~ack);
      if (bus.IO_STRB && ctrl_sel) begin
        tx_ie_reg <= bus.OUT_PORT[1];
        rx_ie_reg <= bus.OUT_PORT[2];
      end
      intr_reg <= (rx_ie_reg & rx_valid_reg) |
                  (tx_ie_reg & tx_empty & ~tx_busy);
    end
  end

  assign bus.INTR = intr_reg;

  always_comb begin
    bus.IN_PORT = 8'h00;
    if (data_sel)
      bus.IN_PORT = rx_data_reg;
    else if (ctrl_sel)
      bus.IN_PORT = {tx_ovf_reg, ferr_reg, rx_ovf_reg, rx_valid_reg,
                     tx_full, tx_empty, tx_busy, 1'b0};
  end

endmodule

// File: tb/tb_rat_uart_io.sv
// Self-checking bench for rat_uart_io with CLKS_PER_BIT=16.
// Table-driven register reads and TX frame bits, plus hand-written
// sequences for FIFO overflow, RX paths, interrupts and mid-frame reset.
module tb_rat_uart_io;

  localparam int CPB = 16;

  logic clk;
  logic rst_n;
  logic rxd;
  logic txd;
  int   passed;
  int   total;

  rat_uart_io_if bus();

  rat_uart_io #(
    .BASE_ID      (8'h40),
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH     (8)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus),
    .RXD   (rxd),
    .TXD   (txd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [7:0] id;
    logic [7:0] exp;
  } rd_vec_t;

  typedef struct {
    logic       txd;
    logic [7:0] status;
  } tx_vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] d);
    bus.PORT_ID = id;
    #1;
    d = bus.IN_PORT;
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] d);
    @(negedge clk);
    bus.IO_STRB  = 1'b1;
    bus.PORT_ID  = id;
    bus.OUT_PORT = d;
    @(negedge clk);
    bus.IO_STRB  = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rd_vec_t    rd_tab [5];
    tx_vec_t    tx_tab [10];
    logic [7:0] d;
    logic [7:0] byte_val;
    logic       start_b, stop_b;
    int         n;

    passed = 0;
    total  = 0;

    rd_tab[0] = '{"rd_data_after_rst", 8'h40, 8'h00};
    rd_tab[1] = '{"rd_status_after_rst", 8'h41, 8'h04};
    rd_tab[2] = '{"rd_unmapped_42", 8'h42, 8'h00};
    rd_tab[3] = '{"rd_unmapped_3f", 8'h3F, 8'h00};
    rd_tab[4] = '{"rd_unmapped_00", 8'h00, 8'h00};

    // 8'hA5 LSB first: 1,0,1,0,0,1,0,1 between start 0 and stop 1.
    tx_tab[0] = '{1'b0, 8'h06};
    tx_tab[1] = '{1'b1, 8'h06};
    tx_tab[2] = '{1'b0, 8'h06};
    tx_tab[3] = '{1'b1, 8'h06};
    tx_tab[4] = '{1'b0, 8'h06};
    tx_tab[5] = '{1'b0, 8'h06};
    tx_tab[6] = '{1'b1, 8'h06};
    tx_tab[7] = '{1'b0, 8'h06};
    tx_tab[8] = '{1'b1, 8'h06};
    tx_tab[9] = '{1'b1, 8'h06};

    // ---- reset with strobe activity ----
    rst_n        = 1'b0;
    rxd          = 1'b1;
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h40;
    bus.OUT_PORT = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.IO_STRB = ~bus.IO_STRB;
    end
    bus.IO_STRB = 1'b0;
    chk("rst_txd", {7'b0, txd}, 8'h01);
    chk("rst_intr", {7'b0, bus.INTR}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      rd(rd_tab[i].id, d);
      chk(rd_tab[i].name, d, rd_tab[i].exp);
    end

    // ---- single byte 8'hA5 ----
    io_write(8'h40, 8'hA5);
    n = 0;
    while (txd !== 1'b0 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", {7'b0, txd}, 8'h00);
    chk("tx_start_latency", {7'b0, (n <= 2)}, 8'h01);
    repeat (CPB / 2 - 1) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_a5_bit%0d", i), {7'b0, txd}, {7'b0, tx_tab[i].txd});
      rd(8'h41, d);
      chk($sformatf("tx_a5_status%0d", i), d, tx_tab[i].status);
      repeat (CPB) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    rd(8'h41, d);
    chk("tx_a5_done_status", d, 8'h04);

    // ---- burst of 10 pushes: first pops at once, 02..09 fill FIFO, 0A dropped ----
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      bus.IO_STRB  = 1'b1;
      bus.PORT_ID  = 8'h40;
      bus.OUT_PORT = 8'(i);
      @(negedge clk);
    end
    bus.IO_STRB = 1'b0;
    rd(8'h41, d);
    chk("burst_full_ovf_status", d, 8'h8A);
    // Now at the 9th negedge after the first start edge: mid start bit.
    for (int k = 0; k < 9; k++) begin
      start_b  = txd;
      byte_val = 8'h00;
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge clk);
        byte_val[b] = txd;
      end
      repeat (CPB) @(negedge clk);
      stop_b = txd;
      chk($sformatf("burst_byte%0d", k), byte_val, 8'(k + 1));
      chk($sformatf("burst_frame%0d", k), {6'b0, start_b, stop_b}, 8'h01);
      if (k < 8) repeat (CPB) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    rd(8'h41, d);
    chk("burst_done_status", d, 8'h84);
    io_write(8'h41, 8'h01);
    rd(8'h41, d);
    chk("burst_ack_status", d, 8'h04);

    // ---- RX single frame with RX_IE ----
    io_write(8'h41, 8'h04);
    send_rx(8'h3C, 1'b1);
    rd(8'h41, d);
    chk("rx_3c_status", d, 8'h14);
    rd(8'h40, d);
    chk("rx_3c_data", d, 8'h3C);
    chk("rx_3c_intr", {7'b0, bus.INTR}, 8'h01);
    io_write(8'h41, 8'h05);
    repeat (2) @(negedge clk);
    rd(8'h41, d);
    chk("rx_ack_status", d, 8'h04);
    chk("rx_ack_intr", {7'b0, bus.INTR}, 8'h00);

    // ---- overrun ----
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd(8'h40, d);
    chk("rx_ovf_data", d, 8'h22);
    rd(8'h41, d);
    chk("rx_ovf_status", d, 8'h34);
    io_write(8'h41, 8'h01);
    rd(8'h41, d);
    chk("rx_ovf_ack_status", d, 8'h04);

    // ---- framing error ----
    send_rx(8'h55, 1'b0);
    rd(8'h41, d);
    chk("rx_ferr_status", d, 8'h44);
    rd(8'h40, d);
    chk("rx_ferr_data_kept", d, 8'h22);
    io_write(8'h41, 8'h01);

    // ---- half-bit glitch ----
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    rd(8'h41, d);
    chk("rx_glitch_status", d, 8'h04);

    // ---- TX interrupt ----
    io_write(8'h41, 8'h02);
    repeat (2) @(negedge clk);
    chk("tx_ie_intr_idle", {7'b0, bus.INTR}, 8'h01);
    io_write(8'h40, 8'h5A);
    @(negedge clk);
    chk("tx_ie_intr_drop", {7'b0, bus.INTR}, 8'h00);
    repeat (10 * CPB + 10) @(negedge clk);
    chk("tx_ie_intr_done", {7'b0, bus.INTR}, 8'h01);

    // ---- reset mid-byte ----
    io_write(8'h40, 8'h00);
    repeat (3 * CPB) @(negedge clk);
    chk("pre_rst_txd_low", {7'b0, txd}, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", {7'b0, txd}, 8'h01);
    chk("mid_rst_intr", {7'b0, bus.INTR}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_txd", {7'b0, txd}, 8'h01);
    rd(8'h41, d);
    chk("post_rst_status", d, 8'h04);
    rd(8'h40, d);
    chk("post_rst_data", d, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
